// File: rtl/sram_bridge_32to16_if.sv
// sram_bridge_32to16_if: CPU-side word port and SRAM-controller half-word port
// of the 32-to-16 bridge. "slave" is the bridge's view; "master" is the
// environment (CPU plus SRAM controller) view.
interface sram_bridge_32to16_if;
  logic        cpu_req;
  logic        cpu_wen;
  logic [8:0]  cpu_addr;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        sram_ce;
  logic        sram_wren;
  logic [9:0]  sram_addr;
  logic [1:0]  sram_byteena;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata;
  logic        sram_wait;

  modport slave (
    input  cpu_req, cpu_wen, cpu_addr, cpu_be, cpu_wdata, sram_rdata, sram_wait,
    output cpu_rdata, cpu_ready, sram_ce, sram_wren, sram_addr, sram_byteena, sram_wdata
  );

  modport master (
    output cpu_req, cpu_wen, cpu_addr, cpu_be, cpu_wdata, sram_rdata, sram_wait,
    input  cpu_rdata, cpu_ready, sram_ce, sram_wren, sram_addr, sram_byteena, sram_wdata
  );
endinterface

// File: rtl/sram_bridge_32to16.sv
// sram_bridge_32to16: splits each latched 32-bit CPU word request into two
// 16-bit SRAM accesses (low half first), paced by sram_wait, and reassembles
// read data. Optional macro SRAM_BRIDGE_SKIP_EMPTY_HALF_EN skips write halves
// whose byte enables are all zero.
module sram_bridge_32to16 (
  input  logic                     clock,
  input  logic                     rst,
  sram_bridge_32to16_if.slave      bus
);

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    LO   = 4'b0010,
    HI   = 4'b0100,
    DONE = 4'b1000
  } state_t;

  state_t      state_q, state_d;
  logic        wen_q;
  logic [8:0]  addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [15:0] lo_q;
  logic [31:0] rdata_q;
  logic        half;

  // State register
  always_ff @(posedge clock or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
`ifdef SRAM_BRIDGE_SKIP_EMPTY_HALF_EN
          if (bus.cpu_wen && (bus.cpu_be[1:0] == 2'b00))
            state_d = (bus.cpu_be[3:2] == 2'b00) ? DONE : HI;
          else
            state_d = LO;
`else
          state_d = LO;
`endif
        end
      end
      LO: begin
        if (!bus.sram_wait) begin
`ifdef SRAM_BRIDGE_SKIP_EMPTY_HALF_EN
          state_d = (wen_q && (be_q[3:2] == 2'b00)) ? DONE : HI;
`else
          state_d = HI;
`endif
        end
      end
      HI:      if (!bus.sram_wait) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch and read-data assembly; cpu_rdata only changes when a read completes
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wen_q   <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      rdata_q <= '0;
    end else begin
      if ((state_q == IDLE) && bus.cpu_req) begin
        wen_q   <= bus.cpu_wen;
        addr_q  <= bus.cpu_addr;
        be_q    <= bus.cpu_be;
        wdata_q <= bus.cpu_wdata;
      end
      if ((state_q == LO) && !bus.sram_wait && !wen_q)
        lo_q <= bus.sram_rdata;
      if ((state_q == HI) && !bus.sram_wait && !wen_q)
        rdata_q <= {bus.sram_rdata, lo_q};
    end
  end

  // Outputs decoded from state and latched request
  always_comb begin
    half             = (state_q == HI);
    bus.sram_ce      = (state_q == LO) || (state_q == HI);
    bus.cpu_ready    = (state_q == DONE);
    bus.sram_wren    = wen_q;
    bus.sram_addr    = {addr_q, half};
    bus.sram_byteena = half ? be_q[3:2] : be_q[1:0];
    bus.sram_wdata   = half ? wdata_q[31:16] : wdata_q[15:0];
    bus.cpu_rdata    = rdata_q;
  end

endmodule

// File: tb/tb_sram_bridge_32to16.sv
// tb_sram_bridge_32to16: the bench plays CPU and SRAM controller against a
// half-word memory array; expected accesses, latency and read data are derived
// from the word-level request.
module tb_sram_bridge_32to16;

  logic clock = 1'b0;
  logic rst;
  always #5 clock = ~clock;

  sram_bridge_32to16_if bus();

  sram_bridge_32to16 dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [15:0] mem [1024];
  logic [31:0] last_rd;
  bit          skip_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // CPU is free to change its inputs once the request is accepted
  task automatic scramble();
    bus.cpu_wen   = 1'($urandom);
    bus.cpu_addr  = 9'($urandom);
    bus.cpu_be    = 4'($urandom);
    bus.cpu_wdata = $urandom;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"},   32'(bus.cpu_ready), 32'd0);
    chk({tag, "_rdata"},   bus.cpu_rdata, 32'd0);
    chk({tag, "_ce"},      32'(bus.sram_ce), 32'd0);
    chk({tag, "_wren"},    32'(bus.sram_wren), 32'd0);
    chk({tag, "_addr"},    32'(bus.sram_addr), 32'd0);
    chk({tag, "_byteena"}, 32'(bus.sram_byteena), 32'd0);
    chk({tag, "_wdata"},   32'(bus.sram_wdata), 32'd0);
  endtask

  // One word transaction with w0/w1 wait cycles on the low/high access
  task automatic run_txn(input logic wen, input logic [8:0] a, input logic [3:0] be,
                         input logic [31:0] wd, input int unsigned w0, input int unsigned w1);
    int unsigned waits [2];
    bit          do_half [2];
    logic [31:0] exp_rd;
    logic [9:0]  ha;
    logic [1:0]  hbe;
    logic [15:0] hwd;
    waits[0] = w0;
    waits[1] = w1;
    exp_rd = {mem[{a, 1'b1}], mem[{a, 1'b0}]};
    for (int h = 0; h < 2; h++)
      do_half[h] = !(skip_en && wen && (be[2*h +: 2] == 2'b00));

    bus.cpu_req   = 1'b1;
    bus.cpu_wen   = wen;
    bus.cpu_addr  = a;
    bus.cpu_be    = be;
    bus.cpu_wdata = wd;
    bus.sram_wait = 1'b1;
    tick();
    bus.cpu_req = 1'b0;
    scramble();

    for (int h = 0; h < 2; h++) begin
      if (do_half[h]) begin
        ha  = {a, h[0]};
        hbe = be[2*h +: 2];
        hwd = wd[16*h +: 16];
        for (int unsigned k = 0; k <= waits[h]; k++) begin
          chk("acc_ce",      32'(bus.sram_ce), 32'd1);
          chk("acc_addr",    32'(bus.sram_addr), 32'(ha));
          chk("acc_byteena", 32'(bus.sram_byteena), 32'(hbe));
          chk("acc_wren",    32'(bus.sram_wren), 32'(wen));
          if (wen) chk("acc_wdata", 32'(bus.sram_wdata), 32'(hwd));
          chk("acc_no_ready", 32'(bus.cpu_ready), 32'd0);
          bus.sram_wait  = (k < waits[h]);
          bus.sram_rdata = (k < waits[h]) ? 16'($urandom) : mem[ha];
          tick();
          if ((k == waits[h]) && wen) begin
            if (hbe[0]) mem[ha][7:0]  = hwd[7:0];
            if (hbe[1]) mem[ha][15:8] = hwd[15:8];
          end
        end
      end
    end

    bus.sram_wait = 1'($urandom);
    chk("done_ready", 32'(bus.cpu_ready), 32'd1);
    chk("done_ce",    32'(bus.sram_ce), 32'd0);
    if (!wen) last_rd = exp_rd;
    chk("done_rdata", bus.cpu_rdata, last_rd);
    tick();
    chk("ready_pulse", 32'(bus.cpu_ready), 32'd0);
    chk("idle_ce",     32'(bus.sram_ce), 32'd0);
    chk("held_rdata",  bus.cpu_rdata, last_rd);
  endtask

  initial begin
    logic [8:0] ta;
    int         last_cyc;
    int         pulses;
    bit         waited;
`ifdef SRAM_BRIDGE_SKIP_EMPTY_HALF_EN
    skip_en = 1'b1;
`else
    skip_en = 1'b0;
`endif
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    last_rd = '0;

    // Reset
    rst            = 1'b1;
    bus.cpu_req    = 1'b0;
    bus.cpu_wen    = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_be     = '0;
    bus.cpu_wdata  = '0;
    bus.sram_rdata = '0;
    bus.sram_wait  = 1'b1;
    #2;
    check_reset_outputs("rst");
    tick();
    tick();
    @(negedge clock);
    rst = 1'b0;
    tick();
    check_reset_outputs("post_rst");

    // Full-word write, one wait per access
    run_txn(1'b1, 9'h005, 4'hF, 32'hA1B2C3D4, 1, 1);

    // Read at top of range
    mem[10'h3FE] = 16'h5678;
    mem[10'h3FF] = 16'h1234;
    run_txn(1'b0, 9'h1FF, 4'hF, 32'h0, 1, 1);
    chk("read_top_value", last_rd, 32'h12345678);

    // Long stall in the low access
    run_txn(1'b1, 9'h033, 4'hF, 32'h0BADF00D, 3, 1);
    run_txn(1'b0, 9'h033, 4'hF, 32'h0, 0, 2);

    // Upper-half-only write
    run_txn(1'b1, 9'h0C7, 4'b1100, 32'hCAFE1111, 1, 1);
    run_txn(1'b1, 9'h0C8, 4'b0011, 32'h2222BEEF, 1, 1);
    run_txn(1'b1, 9'h0C9, 4'b0000, 32'h33334444, 1, 1);
    run_txn(1'b0, 9'h0C7, 4'hF, 32'h0, 1, 1);

    // Back-to-back requests with cpu_req held high
    ta = 9'h111;
    bus.cpu_req   = 1'b1;
    bus.cpu_wen   = 1'b0;
    bus.cpu_addr  = ta;
    bus.cpu_be    = 4'hF;
    bus.cpu_wdata = '0;
    last_cyc = -1;
    pulses   = 0;
    waited   = 1'b0;
    for (int cyc = 0; cyc < 36; cyc++) begin
      if (bus.sram_ce && !waited) begin
        bus.sram_wait = 1'b1;
        waited = 1'b1;
      end else begin
        bus.sram_wait = 1'b0;
        waited = 1'b0;
      end
      bus.sram_rdata = bus.sram_addr[0] ? mem[{ta, 1'b1}] : mem[{ta, 1'b0}];
      tick();
      if (bus.cpu_ready) begin
        if (last_cyc >= 0) chk("ready_spacing", 32'(cyc - last_cyc), 32'd6);
        last_cyc = cyc;
        pulses++;
      end
    end
    bus.cpu_req = 1'b0;
    chk("ready_pulses", 32'(pulses), 32'd6);
    last_rd = {mem[{ta, 1'b1}], mem[{ta, 1'b0}]};
    chk("stream_rdata", bus.cpu_rdata, last_rd);
    tick();
    chk("stream_idle", 32'(bus.cpu_ready), 32'd0);

    // Reset during the high access of a write
    ta = 9'h0AA;
    bus.cpu_req   = 1'b1;
    bus.cpu_wen   = 1'b1;
    bus.cpu_addr  = ta;
    bus.cpu_be    = 4'hF;
    bus.cpu_wdata = 32'h9999AAAA;
    tick();
    bus.cpu_req   = 1'b0;
    scramble();
    bus.sram_wait = 1'b0;
    tick();
    mem[{ta, 1'b0}] = 16'hAAAA;
    chk("rst_hi_ce",   32'(bus.sram_ce), 32'd1);
    chk("rst_hi_addr", 32'(bus.sram_addr), 32'({ta, 1'b1}));
    bus.sram_wait = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    tick();
    chk("rst_no_ready", 32'(bus.cpu_ready), 32'd0);
    #2;
    rst = 1'b0;
    last_rd = '0;
    tick();
    chk("rst_after_ready", 32'(bus.cpu_ready), 32'd0);
    run_txn(1'b0, ta, 4'hF, 32'h0, 1, 1);

    // Randomised traffic
    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom), 9'($urandom), 4'($urandom), $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        tick();
        chk("gap_idle", 32'(bus.cpu_ready), 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
